// File: rtl/instr_fetch_buffer_if.sv
// Bundle of the fetch-side, memory-side and decode-side signals of the instruction fetch buffer.
// slave is the buffer itself; master is whatever surrounds it (PC stage, memory, decode).
interface instr_fetch_buffer_if #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  pc_valid;
  logic                  pc_ready;
  logic [PC_WIDTH-1:0]   pc;
  logic                  flush;
  logic                  mem_en;
  logic [PC_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]   instr_pc;
  logic                  instr_misaligned;

  modport slave (
    input  pc_valid, pc, flush, mem_rdata, instr_ready,
    output pc_ready, mem_en, mem_addr, instr_valid, instr, instr_pc, instr_misaligned
  );

  modport master (
    output pc_valid, pc, flush, mem_rdata, instr_ready,
    input  pc_ready, mem_en, mem_addr, instr_valid, instr, instr_pc, instr_misaligned
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: issues one-cycle-latency instruction memory reads for accepted PCs and
// queues the returned instructions, tagged with their PC, for the decode stage.
module instr_fetch_buffer #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_buffer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
  logic                  mis_q  [DEPTH];

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight_mis;

  logic [AW+1:0] occ;
  logic          fire;
  logic          pop;

  // Occupancy counts the in-flight read so a response always has a slot waiting for it.
  assign occ          = (AW+2)'(count) + (AW+2)'(inflight);
  assign bus.pc_ready = !bus.flush && (occ < (AW+2)'(DEPTH));
  assign fire         = bus.pc_valid && bus.pc_ready;
  assign bus.mem_en   = fire;
  assign bus.mem_addr = fire ? bus.pc : '0;

  assign bus.instr_valid      = (count != '0);
  assign bus.instr            = data_q[rd_ptr];
  assign bus.instr_pc         = pc_q[rd_ptr];
  assign bus.instr_misaligned = mis_q[rd_ptr];
  assign pop                  = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_mis <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        mis_q[i]  <= 1'b0;
      end
    end else if (bus.flush) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fire;
      if (fire) begin
        inflight_pc  <= bus.pc;
        inflight_mis <= |bus.pc[1:0];
      end
      if (inflight) begin
        data_q[wr_ptr] <= bus.mem_rdata;
        pc_q[wr_ptr]   <= inflight_pc;
        mis_q[wr_ptr]  <= inflight_mis;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(inflight) - (AW+1)'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ <= (AW+2)'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: a queue-based model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_instr_fetch_buffer;
  localparam int PW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   pop_cnt = 0;

  instr_fetch_buffer_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_buffer #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [PW-1:0] a);
    if (a == 16'h0004) return 32'h00A0_0093;
    return {~a, a};
  endfunction

  // Synchronous instruction memory; garbage on the bus whenever no read was issued.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= memf(bus.mem_addr);
    else            bus.mem_rdata <= 32'hBAD0_0000 | ($urandom() & 32'hFFFF);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched entries and an optional outstanding request.
  typedef struct {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic          m;
  } ent_t;
  ent_t          mq[$];
  bit            pend;
  logic [PW-1:0] pend_pc;

  function automatic bit m_ready();
    return !bus.flush && (mq.size() + int'(pend) < DEPTH);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      pend = 1'b0;
    end else begin
      bit f;
      f = bus.pc_valid && m_ready();
      if (bus.flush) begin
        mq.delete();
        pend = 1'b0;
      end else begin
        ent_t e;
        if (mq.size() != 0 && bus.instr_ready) void'(mq.pop_front());
        if (pend) begin
          e.d = memf(pend_pc);
          e.p = pend_pc;
          e.m = (pend_pc[1:0] != 2'b00);
          mq.push_back(e);
        end
        pend    = f;
        pend_pc = bus.pc;
      end
    end
    if (bus.instr_valid && bus.instr_ready) pop_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit r;
      r = m_ready();
      chk("m_pc_ready", DW'(bus.pc_ready), DW'(r));
      chk("m_mem_en", DW'(bus.mem_en), DW'(bus.pc_valid && r));
      chk("m_mem_addr", DW'(bus.mem_addr), (bus.pc_valid && r) ? DW'(bus.pc) : '0);
      chk("m_instr_valid", DW'(bus.instr_valid), DW'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_instr", bus.instr, mq[0].d);
        chk("m_instr_pc", DW'(bus.instr_pc), DW'(mq[0].p));
        chk("m_instr_mis", DW'(bus.instr_misaligned), DW'(mq[0].m));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    bit rdy;
    bus.pc_valid = 0; bus.pc = '0; bus.flush = 0; bus.instr_ready = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;

    // 1: reset state and single fetch
    @(negedge clk);
    chk("rst_valid", DW'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", DW'(bus.instr_pc), 0);
    chk("rst_mis", DW'(bus.instr_misaligned), 0);
    chk("rst_mem_en", DW'(bus.mem_en), 0);
    tick();
    bus.pc_valid = 1; bus.pc = 16'h0004;
    @(negedge clk);
    chk("t1_mem_en", DW'(bus.mem_en), 1);
    chk("t1_mem_addr", DW'(bus.mem_addr), 32'h4);
    tick();
    bus.pc_valid = 0;
    @(negedge clk);
    chk("t1_n1_valid", DW'(bus.instr_valid), 0);
    tick();
    @(negedge clk);
    chk("t1_n2_valid", DW'(bus.instr_valid), 1);
    chk("t1_instr", bus.instr, 32'h00A0_0093);
    chk("t1_instr_pc", DW'(bus.instr_pc), 32'h4);
    bus.instr_ready = 1;
    tick();

    // 2: streaming eight fetches with decode always ready
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.pc_valid = 1; bus.pc = PW'(4 * i);
      @(negedge clk);
      chk("t2_pc_ready", DW'(bus.pc_ready), 1);
      tick();
    end
    bus.pc_valid = 0;
    repeat (4) tick();
    chk("t2_pops", DW'(pop_cnt), 8);

    // 3: backpressure fills the buffer, then drains in order
    bus.instr_ready = 0; bus.pc_valid = 1; bus.pc = 16'h0100; acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rdy = bus.pc_ready;
      if (rdy) acc++;
      tick();
      if (rdy) bus.pc = bus.pc + 16'd4;
    end
    @(negedge clk);
    chk("t3_accepts", DW'(acc), 4);
    chk("t3_full_ready", DW'(bus.pc_ready), 0);
    tick();
    bus.pc_valid = 0; bus.instr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_drain_valid", DW'(bus.instr_valid), 1);
      chk("t3_drain_pc", DW'(bus.instr_pc), DW'(32'h100 + 4 * k));
      tick();
    end
    @(negedge clk);
    chk("t3_empty", DW'(bus.instr_valid), 0);
    chk("t3_ready_again", DW'(bus.pc_ready), 1);
    bus.instr_ready = 0;
    tick();

    // 4: flush with three buffered and one in flight
    bus.pc_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus.pc = PW'(32'h300 + 4 * k);
      tick();
    end
    bus.flush = 1; bus.pc = 16'h0200;
    @(negedge clk);
    chk("t4_flush_ready", DW'(bus.pc_ready), 0);
    chk("t4_flush_mem_en", DW'(bus.mem_en), 0);
    tick();
    bus.flush = 0;
    @(negedge clk);
    chk("t4_after_valid", DW'(bus.instr_valid), 0);
    chk("t4_after_mem_en", DW'(bus.mem_en), 1);
    tick();
    bus.pc_valid = 0;
    @(negedge clk);
    chk("t4_n1_valid", DW'(bus.instr_valid), 0);
    tick();
    @(negedge clk);
    chk("t4_n2_valid", DW'(bus.instr_valid), 1);
    chk("t4_n2_pc", DW'(bus.instr_pc), 32'h200);
    chk("t4_n2_instr", bus.instr, 32'hFDFF_0200);

    // 5: push and pop together at count 3, pointers wrapping
    bus.instr_ready = 1;
    tick();
    bus.instr_ready = 0; bus.pc_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus.pc = PW'(32'h400 + 4 * k);
      tick();
    end
    bus.pc_valid = 0; bus.instr_ready = 1;
    @(negedge clk);
    chk("t5_full_ready", DW'(bus.pc_ready), 0);
    chk("t5_head0", DW'(bus.instr_pc), 32'h400);
    tick();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("t5_valid", DW'(bus.instr_valid), 1);
      chk("t5_head", DW'(bus.instr_pc), DW'(32'h400 + 4 * k));
      tick();
    end
    @(negedge clk);
    chk("t5_empty", DW'(bus.instr_valid), 0);
    bus.instr_ready = 0;
    tick();

    // 6: misaligned tag, then reset with entries buffered and one in flight
    bus.pc_valid = 1; bus.pc = 16'h0006;
    tick();
    bus.pc = 16'h0010;
    tick();
    bus.pc_valid = 0;
    @(negedge clk);
    chk("t6_mis_valid", DW'(bus.instr_valid), 1);
    chk("t6_mis_flag", DW'(bus.instr_misaligned), 1);
    chk("t6_mis_pc", DW'(bus.instr_pc), 32'h6);
    bus.pc_valid = 1; bus.pc = 16'h0020;
    tick();
    bus.pc_valid = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_rst_valid", DW'(bus.instr_valid), 0);
    chk("t6_rst_instr", bus.instr, 0);
    chk("t6_rst_pc", DW'(bus.instr_pc), 0);
    chk("t6_rst_mis", DW'(bus.instr_misaligned), 0);
    chk("t6_rst_mem_en", DW'(bus.mem_en), 0);
    tick(); tick();
    @(negedge clk);
    chk("t6_stays_empty", DW'(bus.instr_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Consumer end of the program-counter interface.
- Accepts fetch addresses from the PC stage through a valid/ready handshake and reads a synchronous instruction memory that has a fixed 1-cycle latency.
- Buffers each returned instruction together with its PC in a small FIFO, and presents it to decode through a valid/ready handshake.
- Supports a flush for branch/jump redirects: all buffered and in-flight fetches are discarded.

Parameters:
- PC_WIDTH, 16, width of fetch address / PC tag.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc_valid  in  1  fetch address offered.
- pc_ready  out  1  fetch address accepted this cycle when pc_valid is also high.
- pc  in  PC_WIDTH  byte address to fetch.
- flush  in  1  discard all buffered and in-flight fetches.
- mem_en  out  1  instruction memory read strobe.
- mem_addr  out  PC_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  DATA_WIDTH  head instruction.
- instr_pc  out  PC_WIDTH  PC of head instruction.
- instr_misaligned  out  1  head PC had pc[1:0] != 0.

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high, sampled on posedge clk.
- Reset state:
  - FIFO empty: count=0, read and write pointers 0.
  - inflight=0.
  - All storage cleared, so instr, instr_pc and instr_misaligned read 0.
  - instr_valid=0, mem_en=0.
- Request acceptance:
  - pc_ready = !flush && (count + inflight < DEPTH).
  - Conservative: a same-cycle pop does not free a slot for acceptance.
  - pc_ready does not depend on pc_valid.
- Memory issue (combinational from the accept):
  - fire = pc_valid && pc_ready.
  - mem_en = fire.
  - mem_addr = pc when fire, else 0.
  - On fire, the next cycle sets inflight=1 and captures inflight_pc=pc and inflight_mis=(pc[1:0]!=0).
  - With no fire, inflight=0 next cycle.
  - At most one request is in flight, so sustained throughput is 1 per cycle.
- Response capture:
  - In any cycle with inflight=1 and !flush, write {mem_rdata, inflight_pc, inflight_mis} at the write pointer, advance the write pointer (mod DEPTH), and count+1.
  - Space is guaranteed by the acceptance rule. Overflow is impossible; an assertion checks it.
- Output:
  - instr_valid = (count != 0).
  - instr, instr_pc and instr_misaligned come from the read-pointer entry as registered storage, with no memory-to-output bypass.
  - Pop when instr_valid && instr_ready: advance the read pointer, count-1.
  - Push and pop in the same cycle leave count unchanged.
- Latency: pc accepted in cycle N → mem_en in cycle N → data captured at end of N+1 → instr_valid in N+2 at the earliest.
- Misaligned PC: the fetch is still issued using the PC as given, and the entry is tagged instr_misaligned=1. No other special handling.
- Flush (synchronous, takes effect at the next edge):
  - count=0, pointers=0, inflight=0. The response arriving in the flush cycle is dropped.
  - In the flush cycle, pc_ready=0 and mem_en=0.
  - instr_valid may still be 1 in the flush cycle. A pop in that cycle is permitted, but the FIFO is empty afterwards regardless.
  - Storage contents are not cleared.
- Reset mid-operation: same as the reset state. In-flight data is discarded, and mem_rdata in the cycle after reset is ignored.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Invariant: count + inflight ≤ DEPTH at all times.

Test Plan:
1. Single fetch: after reset, present pc=0x0004 for 1 cycle, memory model returns 0x00A00093 → mem_en=1 and mem_addr=0x0004 in cycle N; instr_valid=1, instr=0x00A00093, instr_pc=0x0004 in N+2.
2. Streaming: pc 0x0000, 0x0004, ... 0x001C on consecutive cycles, instr_ready=1 → pc_ready stays 1; 8 instructions emerge in order, one per cycle from N+2; tags match.
3. Backpressure: instr_ready=0, continuous pc_valid from pc=0x0100 → exactly 4 accepts (0x0100..0x010C); pc_ready=0 once count+inflight=4. Release instr_ready → entries drain in order, then pc_ready=1 again.
4. Flush: with 3 entries buffered and 1 in flight, assert flush 1 cycle → next cycle instr_valid=0, and the in-flight data never appears. A new pc=0x0200 is accepted the cycle after flush and emerges 2 cycles later.
5. Simultaneous push/pop at full-1: count=3 with inflight and pop in the same cycle → count stays 3; no loss or duplication; pointers wrap past index 3 correctly.
6. Misaligned and reset mid-stream: pc=0x0006 → entry has instr_misaligned=1, instr_pc=0x0006. Assert rst while 2 entries are buffered → next cycle instr_valid=0, instr=0, instr_pc=0, mem_en=0.
